mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port unified instruction/data memory between two requesters: the instruction-fetch unit and the load/store unit.
- Runs one access at a time. For each access it drives the memory's address, write_en and execute strobes.
- Captures read data and returns it to the winning requester with a one-cycle valid pulse.
- Sits between the CPU front-end/LSU and the memory; it is the only driver of the memory's control inputs.

Parameters:
- INSTR_SIZE, 16, memory word width (fetch data width)
- DATA_SIZE, 8, data-path width; must be ≤ INSTR_SIZE
- ADDR_SIZE, 8, memory address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  ADDR_SIZE  fetch address
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_valid  out  1  one-cycle pulse, f_rdata valid
- f_rdata  out  INSTR_SIZE  fetched word
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_SIZE  data address
- d_wdata  in  DATA_SIZE  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_valid  out  1  one-cycle pulse, access complete
- d_rdata  out  DATA_SIZE  load data
- mem_addr  out  ADDR_SIZE  to memory current_addr
- mem_write_en  out  1  to memory write_en
- mem_execute  out  1  to memory execute
- mem_in_data  out  DATA_SIZE  to memory in_data
- mem_out_data  in  INSTR_SIZE  from memory, combinational read

Behaviour:
- States: IDLE, ACCESS.
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs 0; latched addr/we/wdata 0.
  - Round-robin pointer favours the data port.
- IDLE:
  - If any request is present, assert exactly one gnt combinationally.
  - At the next rising edge, latch the winner's addr, we (0 for fetch), wdata and port id, then go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_execute = 1.
  - mem_addr = latched addr.
  - mem_write_en = latched we.
  - mem_in_data = latched wdata.
  - At the closing edge:
    - Memory performs any write.
    - Arbiter registers mem_out_data into the rdata register.
    - Pulse valid for the winning port.
    - Go to IDLE.
- Latency: gnt in cycle N, execute in N+1, valid and rdata in N+2.
  - In N+2 the FSM is in IDLE and may grant the next request.
  - Maximum throughput: one access per 2 cycles.
- Read data:
  - f_rdata = full mem_out_data.
  - d_rdata = mem_out_data[DATA_SIZE-1:0].
  - A store also pulses d_valid; its d_rdata is the pre-write contents, because the read is captured on the same edge as the write.
- rdata registers hold their value until the next completion. Valid is 0 in every cycle other than the completion cycle.
- Outside ACCESS:
  - mem_execute = 0 and mem_write_en = 0.
  - mem_addr and mem_in_data hold their last latched values.
- Arbitration (default, round-robin):
  - If only one port requests, it wins.
  - If both request, the port not served last wins.
  - The pointer updates only on a grant.
- Requests are not sampled in ACCESS. gnt is never asserted in ACCESS.
- Reset asserted during ACCESS:
  - Access is aborted and execute drops immediately, so no write occurs.
  - No valid pulse.
  - Requesters must re-issue.
- Requests are level-held. A requester that deasserts before gnt is simply not served.

Optional Feature:
- Macro DATA_PRIORITY_EN.
- Defined: fixed priority, d_req always beats f_req; round-robin pointer is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Reset, then f_req=1, f_addr=0x10 with mem[0x10]=0x1234 -> f_gnt in cycle 1, mem_execute=1 with mem_addr=0x10 in cycle 2, f_valid=1 with f_rdata=0x1234 in cycle 3.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0xAB with mem[0x20]=0x0055 -> mem_write_en=mem_execute=1 for one cycle, d_valid with d_rdata=0x55; a following load of 0x20 returns 0xAB, and the fetch view of 0x20 reads 0x00AB.
- f_req and d_req both held for 4 grants -> grant order D,F,D,F (round-robin); with DATA_PRIORITY_EN -> D,D,D,D while d_req stays high.
- Back-to-back loads from 0x01, 0x02 -> grants 2 cycles apart; the second gnt coincides with the first d_valid.
- Assert rst mid-ACCESS of a store to 0x30 -> mem[0x30] unchanged, no d_valid, all outputs 0 immediately.
- Idle with no requests for 10 cycles -> mem_execute, mem_write_en, f_gnt, d_gnt, f_valid and d_valid all stay 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single-port unified instruction/data memory between the
//   instruction-fetch unit and the load/store unit. One access is run at a
//   time. A request is granted in IDLE, the memory is strobed for exactly
//   one cycle in ACCESS, and read data comes back on the following cycle
//   together with a one-cycle valid pulse to the winning port.
//
// Ports:
//   clk, rst                 system clock (rising edge), async active-high reset
//   f_req, f_addr            fetch request (level-held) and address
//   f_gnt                    fetch accepted this cycle (combinational)
//   f_valid, f_rdata         fetch completion pulse and full memory word
//   d_req, d_we, d_addr,
//   d_wdata                  load/store request (level-held), 1 = store
//   d_gnt                    data request accepted this cycle (combinational)
//   d_valid, d_rdata         data completion pulse and low DATA_SIZE bits
//   mem_addr, mem_write_en,
//   mem_execute, mem_in_data memory control, driven only by this block
//   mem_out_data             combinational read data from the memory
//
// Configuration:
//   DATA_PRIORITY_EN  when defined, the data port always wins a tie and the
//                     round-robin pointer is not built. When undefined
//                     (default), ties alternate between the two ports.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int INSTR_SIZE = 16,
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  f_req,
  input  logic [ADDR_SIZE-1:0]  f_addr,
  output logic                  f_gnt,
  output logic                  f_valid,
  output logic [INSTR_SIZE-1:0] f_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_SIZE-1:0]  d_addr,
  input  logic [DATA_SIZE-1:0]  d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_SIZE-1:0]  d_rdata,

  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic                  mem_write_en,
  output logic                  mem_execute,
  output logic [DATA_SIZE-1:0]  mem_in_data,
  input  logic [INSTR_SIZE-1:0] mem_out_data
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic w_pickData;
  logic w_grantAny;

  logic [ADDR_SIZE-1:0]  r_addr;
  logic                  r_we;
  logic [DATA_SIZE-1:0]  r_wdata;
  logic                  r_portData;

  logic                  r_fValid;
  logic                  r_dValid;
  logic [INSTR_SIZE-1:0] r_fRdata;
  logic [DATA_SIZE-1:0]  r_dRdata;

`ifdef DATA_PRIORITY_EN
  // Fixed priority: any data request beats a fetch request.
  assign w_pickData = d_req;
`else
  logic r_favorData;

  // Round-robin: a lone requester always wins; on a tie the pointer decides.
  assign w_pickData = d_req & (~f_req | r_favorData);

  // The pointer moves only when something is granted, and then points at
  // the port that was not just served. Out of reset the data port is
  // favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_favorData <= 1'b1;
    end else if (w_grantAny) begin
      r_favorData <= ~w_pickData;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the combinational grants and memory strobes.
  // Grants are masked while rst is high so every output reads 0 during
  // reset even if a requester is still holding its request.
  always_comb begin
    w_nextState  = r_state;
    w_grantAny   = 1'b0;
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    mem_execute  = 1'b0;
    mem_write_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && (f_req || d_req)) begin
          w_grantAny  = 1'b1;
          d_gnt       = w_pickData;
          f_gnt       = ~w_pickData;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        mem_execute  = 1'b1;
        mem_write_en = r_we;
        w_nextState  = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request latch and completion capture. On a grant the winner's access is
  // latched; the memory address and write data keep showing these values
  // until the next grant. At the end of ACCESS the memory output is captured
  // on the same edge as any write, so a store returns the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_portData <= 1'b0;
      r_fValid   <= 1'b0;
      r_dValid   <= 1'b0;
      r_fRdata   <= '0;
      r_dRdata   <= '0;
    end else begin
      r_fValid <= 1'b0;
      r_dValid <= 1'b0;
      if (w_grantAny) begin
        r_portData <= w_pickData;
        if (w_pickData) begin
          r_addr  <= d_addr;
          r_we    <= d_we;
          r_wdata <= d_wdata;
        end else begin
          r_addr  <= f_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end
      if (r_state == ACCESS) begin
        if (r_portData) begin
          r_dRdata <= mem_out_data[DATA_SIZE-1:0];
          r_dValid <= 1'b1;
        end else begin
          r_fRdata <= mem_out_data;
          r_fValid <= 1'b1;
        end
      end
    end
  end

  assign mem_addr    = r_addr;
  assign mem_in_data = r_wdata;
  assign f_valid     = r_fValid;
  assign d_valid     = r_dValid;
  assign f_rdata     = r_fRdata;
  assign d_rdata     = r_dRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a behavioural single-port memory
// (combinational read, write on the rising edge while execute and write_en
// are high). Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int INSTR_SIZE = 16;
  localparam int DATA_SIZE  = 8;
  localparam int ADDR_SIZE  = 8;

  logic                  clk;
  logic                  rst;
  logic                  f_req;
  logic [ADDR_SIZE-1:0]  f_addr;
  logic                  f_gnt;
  logic                  f_valid;
  logic [INSTR_SIZE-1:0] f_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_SIZE-1:0]  d_addr;
  logic [DATA_SIZE-1:0]  d_wdata;
  logic                  d_gnt;
  logic                  d_valid;
  logic [DATA_SIZE-1:0]  d_rdata;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic                  mem_write_en;
  logic                  mem_execute;
  logic [DATA_SIZE-1:0]  mem_in_data;
  logic [INSTR_SIZE-1:0] mem_out_data;

  logic [INSTR_SIZE-1:0] mem [0:255];
  logic                  tbWrEn;
  logic [ADDR_SIZE-1:0]  tbWrAddr;
  logic [INSTR_SIZE-1:0] tbWrData;

  int vecCount;
  int missCount;

  mem_port_arbiter #(
    .INSTR_SIZE(INSTR_SIZE),
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_valid     (f_valid),
    .f_rdata     (f_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_valid     (d_valid),
    .d_rdata     (d_rdata),
    .mem_addr    (mem_addr),
    .mem_write_en(mem_write_en),
    .mem_execute (mem_execute),
    .mem_in_data (mem_in_data),
    .mem_out_data(mem_out_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: the bench preload port takes priority; otherwise a store
  // writes the zero-extended data word.
  always @(posedge clk) begin
    if (tbWrEn) begin
      mem[tbWrAddr] <= tbWrData;
    end else if (mem_execute && mem_write_en) begin
      mem[mem_addr] <= {{(INSTR_SIZE-DATA_SIZE){1'b0}}, mem_in_data};
    end
  end

  assign mem_out_data = mem[mem_addr];

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances to just after the next rising edge, where inputs are driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_SIZE-1:0] a, input logic [INSTR_SIZE-1:0] v);
    tbWrEn   = 1'b1;
    tbWrAddr = a;
    tbWrData = v;
    @(posedge clk);
    #1;
    tbWrEn = 1'b0;
  endtask

  logic expD;

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst      = 1'b1;
    tbWrEn   = 1'b0;
    tbWrAddr = '0;
    tbWrData = '0;
    f_req    = 1'b1;
    f_addr   = 8'h10;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 8'h20;
    d_wdata  = 8'h5A;

    preload(8'h10, 16'h1234);
    preload(8'h20, 16'h0055);
    preload(8'h01, 16'h0011);
    preload(8'h02, 16'h0022);
    preload(8'h30, 16'h0077);

    // Reset with both requests held: everything must stay at 0.
    @(negedge clk);
    checkOutput("rst_f_gnt", 32'(f_gnt), 32'h0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'h0);
    checkOutput("rst_exec", 32'(mem_execute), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_indata", 32'(mem_in_data), 32'h0);
    checkOutput("rst_rdata", 32'({f_rdata, d_rdata}), 32'h0);
    f_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    rst   = 1'b0;

    // Single fetch of 0x10.
    applyStimulus();
    f_req  = 1'b1;
    f_addr = 8'h10;
    @(negedge clk);
    checkOutput("f1_gnt", 32'({f_gnt, d_gnt}), 32'h2);
    checkOutput("f1_exec_n", 32'(mem_execute), 32'h0);
    applyStimulus();
    f_req = 1'b0;
    @(negedge clk);
    checkOutput("f1_exec", 32'({mem_execute, mem_write_en}), 32'h2);
    checkOutput("f1_addr", 32'(mem_addr), 32'h10);
    checkOutput("f1_valid_n", 32'(f_valid), 32'h0);
    applyStimulus();
    @(negedge clk);
    checkOutput("f1_valid", 32'({f_valid, d_valid}), 32'h2);
    checkOutput("f1_rdata", 32'(f_rdata), 32'h1234);
    checkOutput("f1_exec_off", 32'(mem_execute), 32'h0);

    // Store 0xAB to 0x20 (previously 0x0055).
    applyStimulus();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h20;
    d_wdata = 8'hAB;
    @(negedge clk);
    checkOutput("st_gnt", 32'({f_gnt, d_gnt}), 32'h1);
    checkOutput("f_valid_pulse", 32'(f_valid), 32'h0);
    applyStimulus();
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    checkOutput("st_exec", 32'({mem_execute, mem_write_en}), 32'h3);
    checkOutput("st_addr", 32'(mem_addr), 32'h20);
    checkOutput("st_indata", 32'(mem_in_data), 32'hAB);
    applyStimulus();
    @(negedge clk);
    checkOutput("st_valid", 32'({f_valid, d_valid}), 32'h1);
    checkOutput("st_rdata", 32'(d_rdata), 32'h55);
    checkOutput("st_mem", 32'(mem[8'h20]), 32'h00AB);
    checkOutput("st_we_off", 32'({mem_execute, mem_write_en}), 32'h0);
    checkOutput("f_rdata_hold", 32'(f_rdata), 32'h1234);

    // Load back 0x20.
    applyStimulus();
    d_req  = 1'b1;
    d_addr = 8'h20;
    @(negedge clk);
    checkOutput("ld_gnt", 32'(d_gnt), 32'h1);
    applyStimulus();
    d_req = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("ld_valid", 32'(d_valid), 32'h1);
    checkOutput("ld_rdata", 32'(d_rdata), 32'hAB);

    // Fetch view of 0x20.
    applyStimulus();
    f_req  = 1'b1;
    f_addr = 8'h20;
    @(negedge clk);
    checkOutput("fv_gnt", 32'(f_gnt), 32'h1);
    applyStimulus();
    f_req = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("fv_valid", 32'(f_valid), 32'h1);
    checkOutput("fv_rdata", 32'(f_rdata), 32'h00AB);
    checkOutput("d_rdata_hold", 32'(d_rdata), 32'hAB);

    // Back-to-back loads from 0x01 then 0x02.
    applyStimulus();
    d_req  = 1'b1;
    d_addr = 8'h01;
    @(negedge clk);
    checkOutput("bb1_gnt", 32'(d_gnt), 32'h1);
    applyStimulus();
    d_addr = 8'h02;
    @(negedge clk);
    checkOutput("bb1_no_gnt", 32'(d_gnt), 32'h0);
    checkOutput("bb1_addr", 32'(mem_addr), 32'h01);
    applyStimulus();
    @(negedge clk);
    checkOutput("bb1_valid", 32'(d_valid), 32'h1);
    checkOutput("bb1_rdata", 32'(d_rdata), 32'h11);
    checkOutput("bb2_gnt", 32'(d_gnt), 32'h1);
    applyStimulus();
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("bb2_addr", 32'(mem_addr), 32'h02);
    checkOutput("bb2_valid_n", 32'(d_valid), 32'h0);
    applyStimulus();
    @(negedge clk);
    checkOutput("bb2_valid", 32'(d_valid), 32'h1);
    checkOutput("bb2_rdata", 32'(d_rdata), 32'h22);

    // Store to 0x30 aborted by reset during ACCESS.
    applyStimulus();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h30;
    d_wdata = 8'hEE;
    @(negedge clk);
    checkOutput("ab_gnt", 32'(d_gnt), 32'h1);
    applyStimulus();
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    checkOutput("ab_exec", 32'({mem_execute, mem_write_en}), 32'h3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ab_exec_drop", 32'({mem_execute, mem_write_en}), 32'h0);
    checkOutput("ab_addr", 32'(mem_addr), 32'h0);
    checkOutput("ab_indata", 32'(mem_in_data), 32'h0);
    checkOutput("ab_rdata", 32'({f_rdata, d_rdata}), 32'h0);
    @(negedge clk);
    checkOutput("ab_mem", 32'(mem[8'h30]), 32'h0077);
    checkOutput("ab_valid", 32'({f_valid, d_valid}), 32'h0);
    rst = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("ab_valid_after", 32'({f_valid, d_valid}), 32'h0);

    // Both ports held for four grants, starting right after reset.
    applyStimulus();
    f_req  = 1'b1;
    f_addr = 8'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'h01;
    for (int g = 0; g < 4; g++) begin
`ifdef DATA_PRIORITY_EN
      expD = 1'b1;
`else
      expD = (g % 2) == 0;
`endif
      @(negedge clk);
      checkOutput($sformatf("rr%0d_gnt", g), 32'({f_gnt, d_gnt}), 32'({~expD, expD}));
      applyStimulus();
      @(negedge clk);
      checkOutput($sformatf("rr%0d_access_gnt", g), 32'({f_gnt, d_gnt}), 32'h0);
      applyStimulus();
    end
    f_req = 1'b0;
    d_req = 1'b0;

    // Drain the last access, then ten idle cycles with no requests.
    applyStimulus();
    applyStimulus();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d", c),
                  32'({mem_execute, mem_write_en, f_gnt, d_gnt, f_valid, d_valid}), 32'h0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
